veri_onbellek_denetleyici: RTL and testbench
============================================

VERI_ONBELLEK_DENETLEYICI -- requirements
Module: veri_onbellek_denetleyici

Interface
REQ-001 SHALL have parameter SATIR_SAYISI, default 16, number of direct-mapped one-word lines (power of two, 4..256).
REQ-002 SHALL have ports: clk_i  in  1  sole clock, all state rising-edge; rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have bib-side inputs: bib_oku_istek_i 1 load request; bib_yaz_gecerli_i 1 store request; bib_adres_i 32 byte address; bib_yaz_veri_i 32 store data, byte-lane aligned; bib_veri_maske_i 4 store byte enables.
REQ-004 SHALL have bib-side outputs: bib_stall_o 1 request not accepted this cycle; bib_oku_gecerli_o 1 load data valid; bib_oku_veri_o 32 aligned load word.
REQ-005 SHALL have memory-side ports: bellek_istek_gecerli_o out 1; bellek_istek_hazir_i in 1; bellek_adres_o out 32, word aligned; bellek_yaz_o out 1, 1=write; bellek_yaz_veri_o out 32; bellek_maske_o out 4; bellek_yanit_gecerli_i in 1; bellek_yanit_veri_i in 32.

Function
REQ-006 SHALL split address as index = adres[log2(SATIR_SAYISI)+1:2], tag = remaining upper bits; adres[1:0] ignored for lookup.
REQ-007 SHALL implement FSM states BOSTA, OKU_ISTEK, OKU_BEKLE, YAZ_ISTEK; requests are accepted only in BOSTA with bib_stall_o=0.
REQ-008 SHALL, on read hit in BOSTA, assert bib_oku_gecerli_o with the line word exactly one cycle later, staying in BOSTA (back-to-back hits at full rate).
REQ-009 SHALL, on read miss in BOSTA, go to OKU_ISTEK and assert bib_stall_o from the next cycle until the miss completes.
REQ-010 SHALL in OKU_ISTEK hold bellek_istek_gecerli_o=1, bellek_yaz_o=0, stable address until bellek_istek_hazir_i=1, then go to OKU_BEKLE.
REQ-011 SHALL in OKU_BEKLE, on bellek_yanit_gecerli_i=1, write word and tag, set valid, return to BOSTA, and assert bib_oku_gecerli_o with that word the following cycle.
REQ-012 SHALL treat stores as write-through, no-write-allocate: on hit, merge bytes under bib_veri_maske_i into the line; on miss, leave array unchanged.
REQ-013 SHALL take every store to YAZ_ISTEK, driving bellek_yaz_o=1, bellek_yaz_veri_o/bellek_maske_o from the request, until bellek_istek_hazir_i=1, then return to BOSTA; no write response is awaited.
REQ-014 SHALL give bib_yaz_gecerli_i priority if asserted together with bib_oku_istek_i; the read is ignored, not queued.
REQ-015 SHALL keep bib_stall_o=1 in every non-BOSTA state and 0 in BOSTA.
REQ-016 SHALL ignore bellek_yanit_gecerli_i outside OKU_BEKLE.
REQ-017 SHALL keep bib_oku_gecerli_o a single-cycle pulse; bib_oku_veri_o holds its last value otherwise.
REQ-018 SHALL keep at most one outstanding memory transaction.

Reset
REQ-019 SHALL on rst_i=0, immediately and regardless of state: FSM to BOSTA, all valid bits 0, bib_oku_gecerli_o=0, bellek_istek_gecerli_o=0, bib_oku_veri_o=0; data/tag arrays need no reset.
REQ-020 SHALL, if reset hits mid-miss, drop the transaction; a later response is ignored per REQ-016.

Structure
REQ-021 SHALL place FSM state encodings and bib/memory port widths in shared package bellek_paket, also used by bellek_islem_birimi.
REQ-022 SHALL isolate tag/valid/data storage in sub-module onbellek_dizisi (one read port, one write port with byte enables, valid-clear on reset).

Verification
REQ-023 Cold read 0x0000_0040: one memory read at 0x40, response 0xDEAD_BEEF -> bib_oku_gecerli_o with 0xDEAD_BEEF one cycle later; repeat read -> hit, no memory request, data next cycle.
REQ-024 Store 0xAABB_CCDD mask 4'b0011 to hit line holding 0x1122_3344 -> memory write with same data/mask, next read returns 0x1122_CCDD without refill.
REQ-025 Store to miss address 0x80 -> one memory write, then read 0x80 -> miss refill (no allocation occurred).
REQ-026 bellek_istek_hazir_i held low 5 cycles -> address/data stable, bib_stall_o=1 throughout, one transaction only.
REQ-027 Reset in OKU_BEKLE, late response after release -> ignored, prior hit line now misses.
REQ-028 Read 0x40 then read 0x440 (same index, different tag, SATIR_SAYISI=16) -> second misses, evicts; re-read 0x40 misses.

Source files
------------

// File: rtl/bellek_paket.sv
// Shared encodings and widths for the data-cache controller and the memory-side unit.
// Holds the FSM state type, the bus widths and the byte-lane merge helper.
package bellek_paket;

  localparam int ADRES_W = 32;
  localparam int VERI_W  = 32;
  localparam int MASKE_W = VERI_W / 8;

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    OKU_ISTEK = 2'd1,
    OKU_BEKLE = 2'd2,
    YAZ_ISTEK = 2'd3
  } durum_t;

  function automatic logic [VERI_W-1:0] bayt_birlestir(
    input logic [VERI_W-1:0]  eski,
    input logic [VERI_W-1:0]  yeni,
    input logic [MASKE_W-1:0] maske
  );
    logic [VERI_W-1:0] sonuc;
    sonuc = eski;
    for (int b = 0; b < MASKE_W; b++) begin
      if (maske[b]) sonuc[b*8 +: 8] = yeni[b*8 +: 8];
    end
    return sonuc;
  endfunction

endpackage

// File: rtl/onbellek_dizisi.sv
// Tag/valid/data storage for a direct-mapped, one-word-per-line cache.
// Combinational read port, byte-enabled write port; only the valid bits are reset.
module onbellek_dizisi
  import bellek_paket::*;
#(
  parameter int SATIR_SAYISI = 16,
  parameter int IDX_W        = $clog2(SATIR_SAYISI),
  parameter int TAG_W        = ADRES_W - 2 - IDX_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   oku_idx,
  output logic               oku_gecerli,
  output logic [TAG_W-1:0]   oku_etiket,
  output logic [VERI_W-1:0]  oku_veri,
  input  logic               yaz_en,
  input  logic [IDX_W-1:0]   yaz_idx,
  input  logic [TAG_W-1:0]   yaz_etiket,
  input  logic [VERI_W-1:0]  yaz_veri,
  input  logic [MASKE_W-1:0] yaz_maske
);

  logic [VERI_W-1:0]       veri_dizi    [SATIR_SAYISI];
  logic [TAG_W-1:0]        etiket_dizi  [SATIR_SAYISI];
  logic [SATIR_SAYISI-1:0] gecerli_dizi;

  assign oku_gecerli = gecerli_dizi[oku_idx];
  assign oku_etiket  = etiket_dizi[oku_idx];
  assign oku_veri    = veri_dizi[oku_idx];

  // A write always leaves the line valid: refills set it, store hits keep it.
  always_ff @(posedge clk_i) begin
    if (yaz_en) begin
      etiket_dizi[yaz_idx] <= yaz_etiket;
      veri_dizi[yaz_idx]   <= bayt_birlestir(veri_dizi[yaz_idx], yaz_veri, yaz_maske);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gecerli_dizi <= '0;
    end else if (yaz_en) begin
      gecerli_dizi[yaz_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/veri_onbellek_denetleyici.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Single outstanding memory transaction; loads return one cycle after a hit or refill.
module veri_onbellek_denetleyici
  import bellek_paket::*;
#(
  parameter int SATIR_SAYISI = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bib_oku_istek_i,
  input  logic               bib_yaz_gecerli_i,
  input  logic [ADRES_W-1:0] bib_adres_i,
  input  logic [VERI_W-1:0]  bib_yaz_veri_i,
  input  logic [MASKE_W-1:0] bib_veri_maske_i,
  output logic               bib_stall_o,
  output logic               bib_oku_gecerli_o,
  output logic [VERI_W-1:0]  bib_oku_veri_o,
  output logic               bellek_istek_gecerli_o,
  input  logic               bellek_istek_hazir_i,
  output logic [ADRES_W-1:0] bellek_adres_o,
  output logic               bellek_yaz_o,
  output logic [VERI_W-1:0]  bellek_yaz_veri_o,
  output logic [MASKE_W-1:0] bellek_maske_o,
  input  logic               bellek_yanit_gecerli_i,
  input  logic [VERI_W-1:0]  bellek_yanit_veri_i
);

  localparam int IDX_W = $clog2(SATIR_SAYISI);
  localparam int TAG_W = ADRES_W - 2 - IDX_W;

  durum_t durum, sonraki;

  logic [ADRES_W-1:2] req_adres;
  logic [VERI_W-1:0]  req_veri;
  logic [MASKE_W-1:0] req_maske;

  logic [IDX_W-1:0]   bib_idx, req_idx;
  logic [TAG_W-1:0]   bib_etiket, req_etiket;
  logic [1:0]         adres_unused;

  logic               dizi_gecerli;
  logic [TAG_W-1:0]   dizi_etiket;
  logic [VERI_W-1:0]  dizi_oku_veri;
  logic               dizi_yaz_en;
  logic [IDX_W-1:0]   dizi_yaz_idx;
  logic [TAG_W-1:0]   dizi_yaz_etiket;
  logic [VERI_W-1:0]  dizi_yaz_veri;
  logic [MASKE_W-1:0] dizi_yaz_maske;

  logic               vurus;
  logic               istek_yakala;
  logic               vurus_oku;
  logic               dolum_bitti;

  logic               vld_p1;
  logic [VERI_W-1:0]  oku_veri_p1;

  // Byte offset plays no part in lookup; the cache holds whole words.
  assign adres_unused = bib_adres_i[1:0];
  assign bib_idx      = bib_adres_i[IDX_W+1:2];
  assign bib_etiket   = bib_adres_i[ADRES_W-1:IDX_W+2];
  assign req_idx      = req_adres[IDX_W+1:2];
  assign req_etiket   = req_adres[ADRES_W-1:IDX_W+2];

  onbellek_dizisi #(
    .SATIR_SAYISI (SATIR_SAYISI),
    .IDX_W        (IDX_W),
    .TAG_W        (TAG_W)
  ) u_dizi (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .oku_idx     (bib_idx),
    .oku_gecerli (dizi_gecerli),
    .oku_etiket  (dizi_etiket),
    .oku_veri    (dizi_oku_veri),
    .yaz_en      (dizi_yaz_en),
    .yaz_idx     (dizi_yaz_idx),
    .yaz_etiket  (dizi_yaz_etiket),
    .yaz_veri    (dizi_yaz_veri),
    .yaz_maske   (dizi_yaz_maske)
  );

  assign vurus = dizi_gecerli && (dizi_etiket == bib_etiket);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum <= BOSTA;
    end else begin
      durum <= sonraki;
    end
  end

  always_comb begin
    sonraki                = durum;
    bib_stall_o            = 1'b1;
    bellek_istek_gecerli_o = 1'b0;
    bellek_yaz_o           = 1'b0;
    istek_yakala           = 1'b0;
    vurus_oku              = 1'b0;
    dolum_bitti            = 1'b0;
    dizi_yaz_en            = 1'b0;
    dizi_yaz_idx           = req_idx;
    dizi_yaz_etiket        = req_etiket;
    dizi_yaz_veri          = bellek_yanit_veri_i;
    dizi_yaz_maske         = '1;
    case (durum)
      BOSTA: begin
        bib_stall_o = 1'b0;
        // A store wins over a simultaneous load; the load is simply dropped.
        if (bib_yaz_gecerli_i) begin
          istek_yakala = 1'b1;
          sonraki      = YAZ_ISTEK;
          if (vurus) begin
            dizi_yaz_en     = 1'b1;
            dizi_yaz_idx    = bib_idx;
            dizi_yaz_etiket = bib_etiket;
            dizi_yaz_veri   = bib_yaz_veri_i;
            dizi_yaz_maske  = bib_veri_maske_i;
          end
        end else if (bib_oku_istek_i) begin
          if (vurus) begin
            vurus_oku = 1'b1;
          end else begin
            istek_yakala = 1'b1;
            sonraki      = OKU_ISTEK;
          end
        end
      end
      OKU_ISTEK: begin
        bellek_istek_gecerli_o = 1'b1;
        if (bellek_istek_hazir_i) sonraki = OKU_BEKLE;
      end
      OKU_BEKLE: begin
        if (bellek_yanit_gecerli_i) begin
          dizi_yaz_en = 1'b1;
          dolum_bitti = 1'b1;
          sonraki     = BOSTA;
        end
      end
      YAZ_ISTEK: begin
        bellek_istek_gecerli_o = 1'b1;
        bellek_yaz_o           = 1'b1;
        if (bellek_istek_hazir_i) sonraki = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (istek_yakala) begin
      req_adres <= bib_adres_i[ADRES_W-1:2];
      req_veri  <= bib_yaz_veri_i;
      req_maske <= bib_veri_maske_i;
    end
  end

  assign bellek_adres_o    = {req_adres, 2'b00};
  assign bellek_yaz_veri_o = req_veri;
  assign bellek_maske_o    = req_maske;

  // Stage p1: load result, one cycle after a hit or a refill response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1      <= 1'b0;
      oku_veri_p1 <= '0;
    end else begin
      vld_p1 <= vurus_oku | dolum_bitti;
      if (vurus_oku) begin
        oku_veri_p1 <= dizi_oku_veri;
      end else if (dolum_bitti) begin
        oku_veri_p1 <= bellek_yanit_veri_i;
      end
    end
  end

  assign bib_oku_gecerli_o = vld_p1;
  assign bib_oku_veri_o    = oku_veri_p1;

endmodule

// File: tb/tb_veri_onbellek_denetleyici.sv
// Directed bench for the data cache controller: a vector table of loads/stores
// with hand-computed results, plus a reset-during-refill sequence.
module tb_veri_onbellek_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bib_oku_istek_i = 1'b0;
  logic        bib_yaz_gecerli_i = 1'b0;
  logic [31:0] bib_adres_i = '0;
  logic [31:0] bib_yaz_veri_i = '0;
  logic [3:0]  bib_veri_maske_i = '0;
  logic        bib_stall_o;
  logic        bib_oku_gecerli_o;
  logic [31:0] bib_oku_veri_o;
  logic        bellek_istek_gecerli_o;
  logic        bellek_istek_hazir_i = 1'b0;
  logic [31:0] bellek_adres_o;
  logic        bellek_yaz_o;
  logic [31:0] bellek_yaz_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_yanit_gecerli_i = 1'b0;
  logic [31:0] bellek_yanit_veri_i = '0;

  int kontrol_say = 0;
  int hata_say    = 0;
  int islem_say   = 0;

  veri_onbellek_denetleyici #(.SATIR_SAYISI(16)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .bib_oku_istek_i        (bib_oku_istek_i),
    .bib_yaz_gecerli_i      (bib_yaz_gecerli_i),
    .bib_adres_i            (bib_adres_i),
    .bib_yaz_veri_i         (bib_yaz_veri_i),
    .bib_veri_maske_i       (bib_veri_maske_i),
    .bib_stall_o            (bib_stall_o),
    .bib_oku_gecerli_o      (bib_oku_gecerli_o),
    .bib_oku_veri_o         (bib_oku_veri_o),
    .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
    .bellek_istek_hazir_i   (bellek_istek_hazir_i),
    .bellek_adres_o         (bellek_adres_o),
    .bellek_yaz_o           (bellek_yaz_o),
    .bellek_yaz_veri_o      (bellek_yaz_veri_o),
    .bellek_maske_o         (bellek_maske_o),
    .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
    .bellek_yanit_veri_i    (bellek_yanit_veri_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory handshakes, counted mid-cycle when the bus is stable.
  always @(negedge clk_i) begin
    if (bellek_istek_gecerli_o && bellek_istek_hazir_i) islem_say++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog gercek=timeout beklenen=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        oku;
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [3:0]  maske;
    logic        iska;
    logic [7:0]  gecikme;
    logic [31:0] bellek_veri;
    logic [31:0] beklenen;
  } vektor_t;

  localparam int N = 15;
  vektor_t tablo [N];
  int      vno;

  function automatic vektor_t vek(input logic oku, input logic yaz, input logic [31:0] adres,
                                  input logic [31:0] veri, input logic [3:0] maske,
                                  input logic iska, input logic [7:0] gecikme,
                                  input logic [31:0] bellek_veri, input logic [31:0] beklenen);
    vektor_t v;
    v.oku = oku; v.yaz = yaz; v.adres = adres; v.veri = veri; v.maske = maske;
    v.iska = iska; v.gecikme = gecikme; v.bellek_veri = bellek_veri; v.beklenen = beklenen;
    return v;
  endfunction

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol_say++;
    if (gercek !== beklenen) begin
      hata_say++;
      $display("FAIL %s vektor=%0d gercek=%h beklenen=%h", ad, vno, gercek, beklenen);
    end
  endtask

  task automatic islem(input vektor_t v);
    int onceki;
    onceki = islem_say;
    @(posedge clk_i); #1;
    bib_oku_istek_i   = v.oku;
    bib_yaz_gecerli_i = v.yaz;
    bib_adres_i       = v.adres;
    bib_yaz_veri_i    = v.veri;
    bib_veri_maske_i  = v.maske;
    @(negedge clk_i);
    kontrol("kabul_stall", {31'd0, bib_stall_o}, 32'd0);
    @(posedge clk_i); #1;
    bib_oku_istek_i   = 1'b0;
    bib_yaz_gecerli_i = 1'b0;
    bib_adres_i       = 32'hFFFF_FFFC;
    bib_yaz_veri_i    = 32'h5A5A_5A5A;
    bib_veri_maske_i  = 4'h0;
    if (v.yaz || v.iska) begin
      for (int i = 0; i <= int'(v.gecikme); i++) begin
        if (i == int'(v.gecikme)) begin
          bellek_istek_hazir_i = 1'b1;
        end else begin
          bellek_yanit_gecerli_i = 1'b1;
          bellek_yanit_veri_i    = 32'hBAD0_0BAD;
        end
        @(negedge clk_i);
        kontrol("istek_stall", {31'd0, bib_stall_o}, 32'd1);
        kontrol("istek_gecerli", {31'd0, bellek_istek_gecerli_o}, 32'd1);
        kontrol("istek_yaz", {31'd0, bellek_yaz_o}, {31'd0, v.yaz});
        kontrol("istek_adres", bellek_adres_o, {v.adres[31:2], 2'b00});
        if (v.yaz) begin
          kontrol("yaz_veri", bellek_yaz_veri_o, v.veri);
          kontrol("yaz_maske", {28'd0, bellek_maske_o}, {28'd0, v.maske});
        end
        @(posedge clk_i); #1;
        bellek_istek_hazir_i   = 1'b0;
        bellek_yanit_gecerli_i = 1'b0;
      end
      if (!v.yaz) begin
        @(negedge clk_i);
        kontrol("bekle_stall", {31'd0, bib_stall_o}, 32'd1);
        kontrol("bekle_istek_yok", {31'd0, bellek_istek_gecerli_o}, 32'd0);
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i    = v.bellek_veri;
        @(posedge clk_i); #1;
        bellek_yanit_gecerli_i = 1'b0;
        @(negedge clk_i);
        kontrol("dolum_vld", {31'd0, bib_oku_gecerli_o}, 32'd1);
        kontrol("dolum_veri", bib_oku_veri_o, v.beklenen);
      end else begin
        @(negedge clk_i);
        kontrol("yaz_sonu_stall", {31'd0, bib_stall_o}, 32'd0);
        kontrol("yaz_sonu_vld", {31'd0, bib_oku_gecerli_o}, 32'd0);
      end
      kontrol("islem_adedi", islem_say - onceki, 32'd1);
    end else begin
      @(negedge clk_i);
      kontrol("vurus_vld", {31'd0, bib_oku_gecerli_o}, 32'd1);
      kontrol("vurus_veri", bib_oku_veri_o, v.beklenen);
      kontrol("vurus_istek_yok", {31'd0, bellek_istek_gecerli_o}, 32'd0);
      kontrol("islem_adedi", islem_say - onceki, 32'd0);
    end
    if (!v.yaz) begin
      @(posedge clk_i);
      @(negedge clk_i);
      kontrol("vld_darbe", {31'd0, bib_oku_gecerli_o}, 32'd0);
      kontrol("veri_tutma", bib_oku_veri_o, v.beklenen);
    end
  endtask

  initial begin
    //            oku yaz adres          veri           maske  iska gec  bellek_veri    beklenen
    tablo[0]  = vek(1, 0, 32'h0000_0040, 32'h0,         4'h0,  1,   0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tablo[1]  = vek(1, 0, 32'h0000_0040, 32'h0,         4'h0,  0,   0, 32'h0,         32'hDEAD_BEEF);
    tablo[2]  = vek(1, 0, 32'h0000_0044, 32'h0,         4'h0,  1,   2, 32'h1122_3344, 32'h1122_3344);
    tablo[3]  = vek(0, 1, 32'h0000_0044, 32'hAABB_CCDD, 4'h3,  0,   0, 32'h0,         32'h0);
    tablo[4]  = vek(1, 0, 32'h0000_0044, 32'h0,         4'h0,  0,   0, 32'h0,         32'h1122_CCDD);
    tablo[5]  = vek(0, 1, 32'h0000_0080, 32'h5566_7788, 4'hF,  0,   5, 32'h0,         32'h0);
    tablo[6]  = vek(1, 0, 32'h0000_0040, 32'h0,         4'h0,  0,   0, 32'h0,         32'hDEAD_BEEF);
    tablo[7]  = vek(1, 0, 32'h0000_0080, 32'h0,         4'h0,  1,   5, 32'h0BAD_F00D, 32'h0BAD_F00D);
    tablo[8]  = vek(1, 0, 32'h0000_0440, 32'h0,         4'h0,  1,   0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tablo[9]  = vek(1, 0, 32'h0000_0040, 32'h0,         4'h0,  1,   1, 32'h0102_0304, 32'h0102_0304);
    tablo[10] = vek(1, 0, 32'h0000_0043, 32'h0,         4'h0,  0,   0, 32'h0,         32'h0102_0304);
    tablo[11] = vek(0, 1, 32'h0000_0047, 32'hFFEE_DDCC, 4'h8,  0,   1, 32'h0,         32'h0);
    tablo[12] = vek(1, 0, 32'h0000_0044, 32'h0,         4'h0,  0,   0, 32'h0,         32'hFF22_CCDD);
    tablo[13] = vek(1, 1, 32'h0000_0048, 32'h1234_5678, 4'hF,  0,   0, 32'h0,         32'h0);
    tablo[14] = vek(1, 0, 32'h0000_0048, 32'h0,         4'h0,  1,   0, 32'h8765_4321, 32'h8765_4321);

    vno = -1;
    @(negedge clk_i);
    kontrol("reset_stall", {31'd0, bib_stall_o}, 32'd0);
    kontrol("reset_vld", {31'd0, bib_oku_gecerli_o}, 32'd0);
    kontrol("reset_veri", bib_oku_veri_o, 32'd0);
    kontrol("reset_istek", {31'd0, bellek_istek_gecerli_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int k = 0; k < N; k++) begin
      vno = k;
      islem(tablo[k]);
    end

    // Reset lands while the refill for 0x4C is waiting for its response.
    vno = 100;
    @(posedge clk_i); #1;
    bib_oku_istek_i = 1'b1;
    bib_adres_i     = 32'h0000_004C;
    @(posedge clk_i); #1;
    bib_oku_istek_i      = 1'b0;
    bellek_istek_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    bellek_istek_hazir_i = 1'b0;
    @(negedge clk_i);
    kontrol("bekle_oncesi_stall", {31'd0, bib_stall_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    kontrol("asenk_reset_stall", {31'd0, bib_stall_o}, 32'd0);
    kontrol("asenk_reset_istek", {31'd0, bellek_istek_gecerli_o}, 32'd0);
    kontrol("asenk_reset_vld", {31'd0, bib_oku_gecerli_o}, 32'd0);
    kontrol("asenk_reset_veri", bib_oku_veri_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    bellek_yanit_gecerli_i = 1'b1;
    bellek_yanit_veri_i    = 32'h9999_9999;
    @(negedge clk_i);
    kontrol("gec_yanit_stall", {31'd0, bib_stall_o}, 32'd0);
    kontrol("gec_yanit_istek", {31'd0, bellek_istek_gecerli_o}, 32'd0);
    @(posedge clk_i); #1;
    bellek_yanit_gecerli_i = 1'b0;
    @(negedge clk_i);
    kontrol("gec_yanit_vld", {31'd0, bib_oku_gecerli_o}, 32'd0);
    kontrol("gec_yanit_veri", bib_oku_veri_o, 32'd0);

    vno = 101;
    islem(vek(1, 0, 32'h0000_0044, 32'h0, 4'h0, 1, 0, 32'h7777_7777, 32'h7777_7777));
    vno = 102;
    islem(vek(1, 0, 32'h0000_004C, 32'h0, 4'h0, 1, 1, 32'h4C4C_4C4C, 32'h4C4C_4C4C));
    vno = 103;
    islem(vek(1, 0, 32'h0000_004C, 32'h0, 4'h0, 0, 0, 32'h0, 32'h4C4C_4C4C));

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_say, hata_say);
    $finish;
  end

endmodule
